exception_ctrl: RTL and testbench



---
 rtl/exception_ctrl.sv | 161 ++++++++++++++++
 tb/tb_exception_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// Commit-stage exception sequencer: owns CP0 EPC/EXL/Cause/BadVAddr and sequences
// flush and fetch redirect for exceptions, interrupts and ERET.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        commit_exception,
  input  logic [4:0]  commit_exccode,
  input  logic [31:0] commit_badvaddr,
  input  logic        commit_eret,
  input  logic [5:0]  int_pending,
  input  logic        status_ie,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] epc,
  output logic        exl,
  output logic [4:0]  cause_exccode,
  output logic        cause_bd,
  output logic [31:0] badvaddr
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StFlush    = 2'd1;
  localparam logic [1:0] StRedirect = 2'd2;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] bva_q, bva_d;

  logic        take_int;
  logic        take_exc;
  logic        accept;
  logic        start;
  logic [4:0]  exc_code;

  assign take_int = status_ie & ~exl_q & (|int_pending);
  assign take_exc = take_int | commit_exception;
  assign accept   = (state_q == StIdle) & commit_valid;
  assign exc_code = take_int ? 5'd0 : commit_exccode;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    code_d  = code_q;
    bd_d    = bd_q;
    bva_d   = bva_q;
    start   = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (take_exc) begin
            start  = 1'b1;
            code_d = exc_code;
            rpc_d  = EXC_VECTOR;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
              epc_d = commit_bd ? (commit_pc - 32'd4) : commit_pc;
              bd_d  = commit_bd;
              exl_d = 1'b1;
            end
            if ((exc_code == ExcAdEL) || (exc_code == ExcAdES)) begin
              bva_d = commit_badvaddr;
            end
          end else if (commit_eret) begin
            start = 1'b1;
            exl_d = 1'b0;
            rpc_d = epc_q;
          end
        end
        if (start) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
          flush_d = 1'b1;
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          state_d = StRedirect;
          flush_d = 1'b0;
          rv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRedirect: begin
        if (redirect_ready) begin
          state_d = StIdle;
          rv_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        flush_d = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= 32'd0;
      epc_q   <= 32'd0;
      exl_q   <= 1'b0;
      code_q  <= 5'd0;
      bd_q    <= 1'b0;
      bva_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      bva_q   <= bva_d;
    end
  end

  assign commit_ready   = (state_q == StIdle);
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign epc            = epc_q;
  assign exl            = exl_q;
  assign cause_exccode  = code_q;
  assign cause_bd       = bd_q;
  assign badvaddr       = bva_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: CP0 state updates, flush/redirect timing,
// priority, nesting, ERET, backpressure and asynchronous reset.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        commit_exception;
  logic [4:0]  commit_exccode;
  logic [31:0] commit_badvaddr;
  logic        commit_eret;
  logic [5:0]  int_pending;
  logic        status_ie;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic [31:0] epc;
  logic        exl;
  logic [4:0]  cause_exccode;
  logic        cause_bd;
  logic [31:0] badvaddr;

  int pass = 0;
  int chk  = 0;

  localparam logic [31:0] VEC = 32'hBFC00380;

  exception_ctrl #(.EXC_VECTOR(32'hBFC00380), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_pc        (commit_pc),
    .commit_bd        (commit_bd),
    .commit_exception (commit_exception),
    .commit_exccode   (commit_exccode),
    .commit_badvaddr  (commit_badvaddr),
    .commit_eret      (commit_eret),
    .int_pending      (int_pending),
    .status_ie        (status_ie),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .epc              (epc),
    .exl              (exl),
    .cause_exccode    (cause_exccode),
    .cause_bd         (cause_bd),
    .badvaddr         (badvaddr)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    commit_valid     = 1'b0;
    commit_pc        = 32'd0;
    commit_bd        = 1'b0;
    commit_exception = 1'b0;
    commit_exccode   = 5'd0;
    commit_badvaddr  = 32'd0;
    commit_eret      = 1'b0;
    int_pending      = 6'd0;
    status_ie        = 1'b0;
  endtask

  // Present one instruction for a single cycle; returns in the cycle after the edge.
  task automatic commit(input logic [31:0] pc, input logic bd, input logic exc,
                        input logic [4:0] code, input logic [31:0] bva, input logic eret,
                        input logic [5:0] ip, input logic ie);
    commit_valid     = 1'b1;
    commit_pc        = pc;
    commit_bd        = bd;
    commit_exception = exc;
    commit_exccode   = code;
    commit_badvaddr  = bva;
    commit_eret      = eret;
    int_pending      = ip;
    status_ie        = ie;
    step();
    clear_inputs();
  endtask

  // Count flush cycles until redirect appears (bounded), then complete the handshake.
  task automatic drain(output int fl, output bit got, output logic [31:0] rpc);
    fl  = 0;
    got = 1'b0;
    rpc = 32'hx;
    for (int i = 0; i < 20 && !got; i++) begin
      if (flush) fl++;
      if (redirect_valid) begin
        got = 1'b1;
        rpc = redirect_pc;
      end else begin
        step();
      end
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    redirect_ready = 1'b0;
    step();
    step();
    chk++; if (flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", flush); else pass++;
    chk++; if (redirect_valid !== 1'b0) $display("FAIL rst_rv: got %b want 0", redirect_valid); else pass++;
    chk++; if (redirect_pc !== 32'd0) $display("FAIL rst_rpc: got %h want 0", redirect_pc); else pass++;
    chk++; if (epc !== 32'd0) $display("FAIL rst_epc: got %h want 0", epc); else pass++;
    chk++; if (exl !== 1'b0) $display("FAIL rst_exl: got %b want 0", exl); else pass++;
    chk++; if (cause_exccode !== 5'd0) $display("FAIL rst_code: got %0d want 0", cause_exccode); else pass++;
    chk++; if (cause_bd !== 1'b0) $display("FAIL rst_bd: got %b want 0", cause_bd); else pass++;
    chk++; if (badvaddr !== 32'd0) $display("FAIL rst_bva: got %h want 0", badvaddr); else pass++;
    reset = 1'b0;
    step();
    chk++; if (commit_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", commit_ready); else pass++;
  endtask

  task automatic test_normal_commit;
    commit(32'h80000100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1);
    chk++; if (commit_ready !== 1'b1) $display("FAIL norm_ready: got %b want 1", commit_ready); else pass++;
    chk++; if (flush !== 1'b0) $display("FAIL norm_flush: got %b want 0", flush); else pass++;
    chk++; if (exl !== 1'b0) $display("FAIL norm_exl: got %b want 0", exl); else pass++;
  endtask

  task automatic test_overflow;
    commit(32'h80001000, 1'b0, 1'b1, 5'd12, 32'd0, 1'b0, 6'd0, 1'b0);
    chk++; if (flush !== 1'b1) $display("FAIL ov_flush1: got %b want 1", flush); else pass++;
    chk++; if (commit_ready !== 1'b0) $display("FAIL ov_ready1: got %b want 0", commit_ready); else pass++;
    chk++; if (epc !== 32'h80001000) $display("FAIL ov_epc: got %h want 80001000", epc); else pass++;
    chk++; if (exl !== 1'b1) $display("FAIL ov_exl: got %b want 1", exl); else pass++;
    chk++; if (cause_exccode !== 5'd12) $display("FAIL ov_code: got %0d want 12", cause_exccode); else pass++;
    chk++; if (redirect_valid !== 1'b0) $display("FAIL ov_rv1: got %b want 0", redirect_valid); else pass++;
    step();
    chk++; if (flush !== 1'b1) $display("FAIL ov_flush2: got %b want 1", flush); else pass++;
    chk++; if (redirect_valid !== 1'b0) $display("FAIL ov_rv2: got %b want 0", redirect_valid); else pass++;
    step();
    chk++; if (flush !== 1'b0) $display("FAIL ov_flush3: got %b want 0", flush); else pass++;
    chk++; if (redirect_valid !== 1'b1) $display("FAIL ov_rv3: got %b want 1", redirect_valid); else pass++;
    chk++; if (redirect_pc !== VEC) $display("FAIL ov_rpc: got %h want %h", redirect_pc, VEC); else pass++;
    chk++; if (commit_ready !== 1'b0) $display("FAIL ov_ready3: got %b want 0", commit_ready); else pass++;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk++; if (redirect_valid !== 1'b0) $display("FAIL ov_rv4: got %b want 0", redirect_valid); else pass++;
    chk++; if (commit_ready !== 1'b1) $display("FAIL ov_ready4: got %b want 1", commit_ready); else pass++;
  endtask

  task automatic test_nested;
    int fl; bit got; logic [31:0] rpc;
    // Taken in the first IDLE cycle after the previous sequence.
    commit(32'h80003000, 1'b0, 1'b1, 5'd9, 32'd0, 1'b0, 6'd0, 1'b0);
    chk++; if (epc !== 32'h80001000) $display("FAIL nest_epc: got %h want 80001000", epc); else pass++;
    chk++; if (cause_exccode !== 5'd9) $display("FAIL nest_code: got %0d want 9", cause_exccode); else pass++;
    chk++; if (exl !== 1'b1) $display("FAIL nest_exl: got %b want 1", exl); else pass++;
    drain(fl, got, rpc);
    chk++; if (!got || rpc !== VEC) $display("FAIL nest_rpc: got %h (seen %b) want %h", rpc, got, VEC); else pass++;
    chk++; if (fl !== 2) $display("FAIL nest_flushlen: got %0d want 2", fl); else pass++;
    commit(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 6'd0, 1'b0);
    chk++; if (exl !== 1'b0) $display("FAIL nest_eret_exl: got %b want 0", exl); else pass++;
    drain(fl, got, rpc);
    chk++; if (!got || rpc !== 32'h80001000) $display("FAIL nest_eret_rpc: got %h (seen %b) want 80001000", rpc, got); else pass++;
  endtask

  task automatic test_adel_bd;
    int fl; bit got; logic [31:0] rpc;
    commit(32'h80002004, 1'b1, 1'b1, 5'd4, 32'h1235, 1'b0, 6'd0, 1'b0);
    chk++; if (epc !== 32'h80002000) $display("FAIL adel_epc: got %h want 80002000", epc); else pass++;
    chk++; if (cause_bd !== 1'b1) $display("FAIL adel_bd: got %b want 1", cause_bd); else pass++;
    chk++; if (badvaddr !== 32'h1235) $display("FAIL adel_bva: got %h want 1235", badvaddr); else pass++;
    chk++; if (cause_exccode !== 5'd4) $display("FAIL adel_code: got %0d want 4", cause_exccode); else pass++;
    drain(fl, got, rpc);
    commit(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 6'd0, 1'b0);
    drain(fl, got, rpc);
    chk++; if (!got || rpc !== 32'h80002000) $display("FAIL adel_eret_rpc: got %h (seen %b) want 80002000", rpc, got); else pass++;
    commit(32'h80004000, 1'b0, 1'b1, 5'd8, 32'hDEAD0000, 1'b0, 6'd0, 1'b0);
    chk++; if (badvaddr !== 32'h1235) $display("FAIL sys_bva: got %h want 1235", badvaddr); else pass++;
    chk++; if (cause_exccode !== 5'd8) $display("FAIL sys_code: got %0d want 8", cause_exccode); else pass++;
    chk++; if (cause_bd !== 1'b0) $display("FAIL sys_bd: got %b want 0", cause_bd); else pass++;
    chk++; if (epc !== 32'h80004000) $display("FAIL sys_epc: got %h want 80004000", epc); else pass++;
    drain(fl, got, rpc);
  endtask

  task automatic test_eret_hold;
    commit(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 6'd0, 1'b0);
    chk++; if (exl !== 1'b0) $display("FAIL eret_exl: got %b want 0", exl); else pass++;
    step();
    step();
    // Redirect is pending; a competing exception must be ignored while held.
    commit_valid     = 1'b1;
    commit_exception = 1'b1;
    commit_exccode   = 5'd12;
    commit_pc        = 32'h80009000;
    for (int i = 0; i < 5; i++) begin
      chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80004000)
        $display("FAIL eret_hold%0d: got rv=%b pc=%h want rv=1 pc=80004000", i, redirect_valid, redirect_pc);
      else pass++;
      step();
    end
    clear_inputs();
    chk++; if (commit_ready !== 1'b0) $display("FAIL eret_hold_ready: got %b want 0", commit_ready); else pass++;
    chk++; if (cause_exccode !== 5'd8 || exl !== 1'b0)
      $display("FAIL eret_hold_ignore: got code=%0d exl=%b want code=8 exl=0", cause_exccode, exl);
    else pass++;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk++; if (redirect_valid !== 1'b0 || commit_ready !== 1'b1)
      $display("FAIL eret_release: got rv=%b ready=%b want rv=0 ready=1", redirect_valid, commit_ready);
    else pass++;
  endtask

  task automatic test_int_priority;
    int fl; bit got; logic [31:0] rpc;
    commit(32'h80005000, 1'b0, 1'b1, 5'd10, 32'd0, 1'b0, 6'b000100, 1'b1);
    chk++; if (cause_exccode !== 5'd0) $display("FAIL int_code: got %0d want 0", cause_exccode); else pass++;
    chk++; if (epc !== 32'h80005000) $display("FAIL int_epc: got %h want 80005000", epc); else pass++;
    drain(fl, got, rpc);
    chk++; if (!got || rpc !== VEC) $display("FAIL int_rpc: got %h (seen %b) want %h", rpc, got, VEC); else pass++;
    commit(32'h80005100, 1'b0, 1'b1, 5'd10, 32'd0, 1'b0, 6'b000100, 1'b1);
    chk++; if (cause_exccode !== 5'd10) $display("FAIL int_exl_code: got %0d want 10", cause_exccode); else pass++;
    chk++; if (epc !== 32'h80005000) $display("FAIL int_exl_epc: got %h want 80005000", epc); else pass++;
    drain(fl, got, rpc);
    commit(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 6'd0, 1'b0);
    drain(fl, got, rpc);
  endtask

  task automatic test_reset_mid_flush;
    commit(32'h80006000, 1'b0, 1'b1, 5'd12, 32'd0, 1'b0, 6'd0, 1'b0);
    step();
    chk++; if (flush !== 1'b1 || exl !== 1'b1)
      $display("FAIL rmf_pre: got flush=%b exl=%b want 1 1", flush, exl);
    else pass++;
    reset = 1'b1;
    #1;
    chk++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || exl !== 1'b0 || epc !== 32'd0)
      $display("FAIL rmf_async: got flush=%b rv=%b exl=%b epc=%h want 0 0 0 0",
               flush, redirect_valid, exl, epc);
    else pass++;
    step();
    reset = 1'b0;
    step();
    chk++; if (commit_ready !== 1'b1) $display("FAIL rmf_ready: got %b want 1", commit_ready); else pass++;
    for (int i = 0; i < 4; i++) begin
      chk++; if (redirect_valid !== 1'b0 || flush !== 1'b0)
        $display("FAIL rmf_drop%0d: got rv=%b flush=%b want 0 0", i, redirect_valid, flush);
      else pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_normal_commit();
    test_overflow();
    test_nested();
    test_adel_bd();
    test_eret_hold();
    test_int_priority();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
